// File: rtl/uart_rx_frame_if.sv
// ============================================================================
//  Module      : uart_rx_frame_if
//  Description : Signal bundle between the serial line, the frame receiver
//                and the downstream Hamming decoder.
//                  rxd           - asynchronous serial line, idles high
//                  ack           - consumer has taken the held codeword
//                  data_out[7:0] - received data, bit 0 first on the line
//                  edc_out[3:0]  - received EDC bits, edc_out[0] first
//                  valid         - held codeword is new and unacknowledged
//                  framing_error - one-cycle pulse on a low stop bit
//                  overrun       - sticky: a frame completed while valid=1
//                  busy          - receiver is not idle
//                master : the receiver side (drives the codeword/status)
//                slave  : the line/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_frame_if;
    logic       rxd;
    logic       ack;
    logic [7:0] data_out;
    logic [3:0] edc_out;
    logic       valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    modport master (
        input  rxd,
        input  ack,
        output data_out,
        output edc_out,
        output valid,
        output framing_error,
        output overrun,
        output busy
    );

    modport slave (
        output rxd,
        output ack,
        input  data_out,
        input  edc_out,
        input  valid,
        input  framing_error,
        input  overrun,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
//  Module      : uart_rx_frame
//  Description : UART frame receiver. Recovers one 12-bit codeword (8 data +
//                4 EDC bits) per frame: start(0), data LSB first, edc[0]
//                first, stop(1). The codeword is held until acknowledged.
//  Ports       : clk      - system clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - uart_rx_frame_if.master (rxd, ack, data_out,
//                           edc_out, valid, framing_error, overrun, busy)
//  Parameters  : CLKS_PER_BIT - clock cycles per serial bit, even, 8..4095
//  Options     : UART_RX_MAJORITY_VOTE_EN - when defined, every bit decision
//                is the 2-of-3 majority of rxd_s at P-1, P and P+1, taken at
//                P+1 (all decisions move one cycle later).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    uart_rx_frame_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // End-of-bit count. With majority voting the start decision is taken one
    // cycle later; since the bit counter restarts from that later point, all
    // subsequent decisions slip by the same single cycle without changing
    // the SHIFT/STOP compare value.
    localparam logic [11:0] c_bit_end  = 12'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [11:0] c_start_pt = 12'(CLKS_PER_BIT / 2);
`else
    localparam logic [11:0] c_start_pt = 12'(CLKS_PER_BIT / 2 - 1);
`endif

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rxd_s_q, rxd_s_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [11:0] sr_q, sr_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  edc_q, edc_d;
    logic        valid_q, valid_d;
    logic        fe_q, fe_d;
    logic        ovr_q, ovr_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]  hist_q, hist_d;   // [0] = rxd_s one cycle ago, [1] = two
`endif

    logic        w_sample;
    logic        w_load;
    logic        w_ack;

    // ------------------------------------------------------------------------
    // Bit decision
    // ------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign w_sample = (hist_q[1] & hist_q[0]) |
                      (hist_q[1] & rxd_s_q)   |
                      (hist_q[0] & rxd_s_q);
`else
    assign w_sample = rxd_s_q;
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
            cnt_q   <= 12'd0;
            idx_q   <= 4'd0;
            sr_q    <= 12'd0;
            data_q  <= 8'h00;
            edc_q   <= 4'h0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            hist_q  <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rxd_s_q <= rxd_s_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            edc_q   <= edc_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            hist_q  <= hist_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sync1_d = bus.rxd;
        rxd_s_d = sync1_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        data_d  = data_q;
        edc_d   = edc_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ovr_d   = ovr_q;
        w_load  = 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
        hist_d  = {hist_q[0], rxd_s_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = 12'd0;
                    idx_d   = 4'd0;
                end
            end

            S_START: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == c_start_pt) begin
                    // A high sample here is a line glitch, not a start bit.
                    state_d = w_sample ? S_IDLE : S_SHIFT;
                    cnt_d   = 12'd0;
                    idx_d   = 4'd0;
                end
            end

            S_SHIFT: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == c_bit_end) begin
                    cnt_d = 12'd0;
                    // Entering from the MSB end leaves the first bit in sr[0].
                    sr_d  = {w_sample, sr_q[11:1]};
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd11) begin
                        state_d = S_STOP;
                        idx_d   = 4'd0;
                    end
                end
            end

            S_STOP: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == c_bit_end) begin
                    cnt_d = 12'd0;
                    if (w_sample) begin
                        w_load  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // Hold here while the line stays low so a break condition
                // cannot be mistaken for a stream of start bits.
                cnt_d = 12'd0;
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 12'd0;
                idx_d   = 4'd0;
            end
        endcase

        // Acknowledge retires the old word before any same-cycle load is
        // considered, so a load coinciding with ack is not an overrun.
        w_ack = valid_q & bus.ack;
        if (w_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (w_load) begin
            if (!valid_q || w_ack) begin
                data_d  = sr_q[7:0];
                edc_d   = sr_q[11:8];
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end
    end

    assign bus.data_out      = data_q;
    assign bus.edc_out       = edc_q;
    assign bus.valid         = valid_q;
    assign bus.framing_error = fe_q;
    assign bus.overrun       = ovr_q;
    assign bus.busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
//  Module      : tb_uart_rx_frame
//  Description : Self-checking bench for uart_rx_frame. Expected codewords
//                are queued when a frame is driven and compared when valid
//                rises; directed steps check timing, overrun, glitch
//                rejection, break handling and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int N = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT         = 218;
    localparam int GLITCH_IDLE = N / 2 + 2;
`else
    localparam int LAT         = 217;
    localparam int GLITCH_IDLE = N / 2 + 1;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] e;
    } word_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    word_t exp_q[$];
    word_t sb_w;
    int    rise_cyc  = -1;
    int    fe_cnt    = 0;
    int    fe_cyc    = -1;
    logic  prev_valid = 1'b0;

    int    e0;
    int    fe0;

    uart_rx_frame_if bus();

    uart_rx_frame #(.CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: pop and compare on every rising edge of valid.
    always @(negedge clk) begin
        if (bus.framing_error === 1'b1) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (bus.valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cyc = cyc;
            chk("sb_word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                sb_w = exp_q.pop_front();
                chk("sb_data", {24'd0, bus.data_out}, {24'd0, sb_w.d});
                chk("sb_edc",  {28'd0, bus.edc_out},  {28'd0, sb_w.e});
            end
        end
        prev_valid = bus.valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.rxd = b;
        repeat (N) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [3:0] e, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        for (int i = 0; i < 4; i++) drive_bit(e[i]);
        drive_bit(stop);
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
    task automatic drive_bit_spike(input logic b);
        bus.rxd = b;
        repeat (N / 2) tick();
        bus.rxd = ~b;
        tick();
        bus.rxd = b;
        repeat (N / 2 - 1) tick();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rxd = 1'b1;
        bus.ack = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.valid},         32'd0);
        chk("rst_fe",    {31'd0, bus.framing_error}, 32'd0);
        chk("rst_ovr",   {31'd0, bus.overrun},       32'd0);
        chk("rst_busy",  {31'd0, bus.busy},          32'd0);
        chk("rst_data",  {24'd0, bus.data_out},      32'd0);
        chk("rst_edc",   {28'd0, bus.edc_out},       32'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // Single frame, latency and hold-until-ack.
        e0 = cyc;
        exp_q.push_back('{d: 8'hA5, e: 4'h6});
        send_frame(8'hA5, 4'h6, 1'b1);
        chk("a5_rise_cycle", rise_cyc, e0 + 2 + LAT);
        repeat (50) tick();
        chk("a5_valid_held", {31'd0, bus.valid},    32'd1);
        chk("a5_data_held",  {24'd0, bus.data_out}, 32'hA5);
        chk("a5_edc_held",   {28'd0, bus.edc_out},  32'h6);
        ack_pulse();
        chk("a5_valid_acked", {31'd0, bus.valid},    32'd0);
        chk("a5_data_kept",   {24'd0, bus.data_out}, 32'hA5);
        repeat (8) tick();

        // Back-to-back frames without ack: second word is dropped.
        e0 = cyc;
        exp_q.push_back('{d: 8'h3C, e: 4'h1});
        send_frame(8'h3C, 4'h1, 1'b1);
        send_frame(8'hC3, 4'hE, 1'b1);
        chk("ovr_rise_cycle", rise_cyc, e0 + 2 + LAT);
        chk("ovr_flag",       {31'd0, bus.overrun},  32'd1);
        chk("ovr_valid",      {31'd0, bus.valid},    32'd1);
        chk("ovr_data_kept",  {24'd0, bus.data_out}, 32'h3C);
        chk("ovr_edc_kept",   {28'd0, bus.edc_out},  32'h1);
        ack_pulse();
        chk("ovr_ack_valid", {31'd0, bus.valid},   32'd0);
        chk("ovr_ack_flag",  {31'd0, bus.overrun}, 32'd0);
        repeat (8) tick();

        // Short low glitch is rejected as a false start.
        fe0 = fe_cnt;
        e0  = cyc;
        bus.rxd = 1'b0;
        repeat (5) tick();
        bus.rxd = 1'b1;
        chk("glitch_busy_seen", {31'd0, bus.busy}, 32'd1);
        while (cyc < e0 + 2 + GLITCH_IDLE) tick();
        chk("glitch_busy_clear", {31'd0, bus.busy}, 32'd0);
        repeat (3 * N) tick();
        chk("glitch_no_valid", {31'd0, bus.valid}, 32'd0);
        chk("glitch_no_fe",    fe_cnt,             fe0);

        // Low stop bit followed by a long break, then a good frame.
        fe0 = fe_cnt;
        e0  = cyc;
        send_frame(8'h77, 4'h2, 1'b0);
        repeat (40 * N) tick();
        chk("brk_fe_once",   fe_cnt - fe0,       32'd1);
        chk("brk_fe_cycle",  fe_cyc,             e0 + 2 + LAT);
        chk("brk_busy_hold", {31'd0, bus.busy},  32'd1);
        chk("brk_no_valid",  {31'd0, bus.valid}, 32'd0);
        bus.rxd = 1'b1;
        repeat (4) tick();
        chk("brk_busy_clear", {31'd0, bus.busy}, 32'd0);
        repeat (2 * N) tick();
        e0 = cyc;
        exp_q.push_back('{d: 8'h5A, e: 4'h9});
        send_frame(8'h5A, 4'h9, 1'b1);
        chk("brk_5a_rise", rise_cyc, e0 + 2 + LAT);
        chk("brk_fe_none_more", fe_cnt - fe0, 32'd1);
        repeat (8) tick();

        // Asynchronous reset in the middle of a frame (5A still held).
        chk("mid_valid_pre", {31'd0, bus.valid}, 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        bus.rxd = 1'b1;
        repeat (N / 2) tick();
        chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.valid},         32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy},          32'd0);
        chk("mid_rst_data",  {24'd0, bus.data_out},      32'd0);
        chk("mid_rst_edc",   {28'd0, bus.edc_out},       32'd0);
        chk("mid_rst_ovr",   {31'd0, bus.overrun},       32'd0);
        chk("mid_rst_fe",    {31'd0, bus.framing_error}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (2 * N) tick();
        e0 = cyc;
        exp_q.push_back('{d: 8'hFF, e: 4'hF});
        send_frame(8'hFF, 4'hF, 1'b1);
        chk("mid_ff_rise", rise_cyc, e0 + 2 + LAT);
        ack_pulse();
        repeat (8) tick();

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-cycle inverted spike at every mid-bit is outvoted.
        e0 = cyc;
        exp_q.push_back('{d: 8'h00, e: 4'h0});
        drive_bit_spike(1'b0);
        for (int i = 0; i < 12; i++) drive_bit_spike(1'b0);
        drive_bit_spike(1'b1);
        chk("maj_rise", rise_cyc, e0 + 2 + LAT);
        chk("maj_valid", {31'd0, bus.valid}, 32'd1);
        ack_pulse();
        repeat (8) tick();
`endif

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receiver stage feeding the Hamming decoder on the UART receive path. Recovers one 12-bit codeword (8 data bits plus 4 EDC bits) per frame from the asynchronous `rxd` line. Validates start and stop bits, then holds the codeword in an output register until the consumer acknowledges it. The outputs `data_out`/`edc_out` connect directly to the decoder's `data_in`/`edc_in`.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit.
  - Legal range is 8..4095, even values only.
  - The counter is 12 bits wide.
- `clk` input, 1 bit: system clock, rising-edge.
- `reset_n` input, 1 bit: reset; one clock; reset is asynchronous and active-low.
- `rxd` input, 1 bit: asynchronous serial line; idles high.
- `ack` input, 1 bit: consumer has taken the held codeword; sampled only while `valid`=1.
- `data_out` output, 8 bits: received data, bit 0 received first.
- `edc_out` output, 4 bits: received EDC bits, `edc_out[0]` received first after data bit 7.
- `valid` output, 1 bit: the held codeword is new and not yet acknowledged.
- `framing_error` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `overrun` output, 1 bit: sticky flag; a frame completed while `valid`=1. Cleared by `ack`.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer to give `rxd_s`, which resets to 1. All logic uses `rxd_s` only.
- Frame format:
  - 1 start bit (0).
  - 8 data bits, LSB first.
  - 4 EDC bits, `edc[0]` first.
  - 1 stop bit (1).
- The bit counter `cnt` is 12 bits and the bit index `idx` is 4 bits. Both clear on every state change.
- **IDLE**: when `rxd_s`=0, go to START with `cnt`=0.
- **START**: `cnt` increments every cycle. At the sample point `cnt`=CLKS_PER_BIT/2−1:
  - if the sample is 0, go to SHIFT;
  - if the sample is 1, it is a false start: go to IDLE with no output change.
- **SHIFT**: at each sample point `cnt`=CLKS_PER_BIT−1, the sample is shifted into a 12-bit shift register from the MSB end, `idx` increments, and `cnt` clears. After `idx` reaches 12, go to STOP.
- **STOP**: sample at `cnt`=CLKS_PER_BIT−1.
  - Sample 1, `valid`=0: load `data_out`/`edc_out`, set `valid`, go to IDLE.
  - Sample 1, `valid`=1: set `overrun`, keep the held word (the new word is dropped), go to IDLE.
  - Sample 0: pulse `framing_error` for one cycle, drop the word, go to BREAK.
- **BREAK**: wait until `rxd_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- `ack`=1 while `valid`=1 clears `valid` and `overrun` on the next edge. `ack` is ignored while `valid`=0.
- Same-cycle load and `ack`: `ack` applies to the old word first, so the new word loads, `valid` stays 1, and `overrun` is not set.
- `data_out`/`edc_out` change only on a load; otherwise they hold their value indefinitely.

## Timing
- Reset values:
  - `valid`=0, `framing_error`=0, `overrun`=0, `busy`=0;
  - `data_out`=8'h00, `edc_out`=4'h0;
  - state IDLE, synchronizer flops at 1.
- Reset mid-frame aborts immediately. The receiver resumes with the next falling edge on `rxd_s` after `reset_n` deasserts.
- Pin-to-`rxd_s` latency is 2 cycles.
- Let T0 be the first edge at which the FSM sees `rxd_s`=0 in IDLE (START is entered at T0+1).
  - Start-bit sample point: T0+CLKS_PER_BIT/2.
  - Sample point of bit k (k=1..12): T0+CLKS_PER_BIT/2+k·CLKS_PER_BIT.
  - Stop-bit sample point: T0+CLKS_PER_BIT/2+13·CLKS_PER_BIT.
  - `valid` or `framing_error` rises 1 cycle after the stop-bit sample point.
- With `CLKS_PER_BIT`=16: stop sample at T0+216, `valid` high from T0+217.
- IDLE is re-entered in the cycle after the stop sample, so back-to-back frames with a one-bit stop are accepted.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - each sample point takes 3 samples of `rxd_s`, at cycles P−1, P and P+1;
  - the decision is the 2-of-3 majority, taken at P+1;
  - all decision times above move 1 cycle later, so `valid` rises at T0+218 for N=16;
  - the false-start check also uses the majority.
- Macro undefined: a single sample at P; timing exactly as above.

## Test plan
- Frame data 8'hA5, edc 4'h6, N=16, `ack` held low → `valid` rises at T0+217; `data_out`=8'hA5, `edc_out`=4'h6; both stay stable until `ack`.
- Two frames (8'h3C/4'h1, then 8'hC3/4'hE) with no `ack` → `overrun`=1 after the second stop; `data_out` still 8'h3C. A subsequent `ack` clears `valid` and `overrun`.
- A 0.3-bit low glitch on `rxd` → no `valid`, no `framing_error`; `busy` returns to 0 by T0+N/2+1.
- Stop bit driven low, line held low for 40 bit times → one `framing_error` pulse only. The FSM stays in BREAK until the line rises, and a following good frame 8'h5A/4'h9 is received correctly.
- `reset_n` pulsed low at bit 6 of a frame → all outputs return to reset values at once. The next full frame 8'hFF/4'hF is received.
- With `UART_RX_MAJORITY_VOTE_EN`: a 1-cycle inverted spike at each mid-bit of frame 8'h00/4'h0 → word received unchanged; `valid` at T0+218.
